// File: rtl/matmul_flags_ctrl.sv
// Sequencer for one matmul run: starts and clears the datapath, ORs per-PE overflow bits
// into a sticky accumulator, commits them to the flags register, and gates host writes.
module matmul_flags_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  parameter int NF         = MAX_DIM * MAX_DIM,
  parameter int CW         = $clog2(MAX_DIM + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CW-1:0]        k_i,
  input  logic                 abort_i,
  input  logic                 pe_valid_i,
  input  logic [NF-1:0]        pe_ovf_i,
  input  logic                 host_we_i,
  input  logic [BUS_WIDTH-1:0] host_data_i,
  output logic                 mm_start_o,
  output logic                 mm_clear_o,
  output logic                 flags_we_o,
  output logic [BUS_WIDTH-1:0] flags_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o,
  output logic                 ovf_any_o,
  output logic                 host_err_o,
  output logic [2:0]           dbg_state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CW-1:0] K_MAX = CW'(MAX_DIM);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NF-1:0] acc_q, acc_d;
  logic          ovf_any_q, ovf_any_d;
  logic          aborted_q, aborted_d;
  logic          host_err_q, host_err_d;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ovf_any_d  = ovf_any_q;
    aborted_d  = 1'b0;
    // Host writes are only legal while idle; anything else is dropped and flagged.
    host_err_d = host_we_i && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          k_d     = ((k_i == '0) || (k_i > K_MAX)) ? K_MAX : k_i;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_CLEAR: begin
        if (abort_i) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over a final beat arriving on the same edge.
        if (abort_i) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (pe_valid_i) begin
          acc_d = acc_q | pe_ovf_i;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == k_q - CW'(1)) begin
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        ovf_any_d = |acc_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mm_start_o   = (state_q == S_CLEAR);
    mm_clear_o   = (state_q == S_CLEAR);
    busy_o       = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_COMMIT);
    done_o       = (state_q == S_DONE);
    flags_we_o   = 1'b0;
    flags_data_o = '0;
    if (state_q == S_IDLE) begin
      flags_we_o   = host_we_i;
      flags_data_o = host_we_i ? host_data_i : '0;
    end else if (state_q == S_COMMIT) begin
      flags_we_o   = 1'b1;
      flags_data_o = BUS_WIDTH'(acc_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ovf_any_q  <= 1'b0;
      aborted_q  <= 1'b0;
      host_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ovf_any_q  <= ovf_any_d;
      aborted_q  <= aborted_d;
      host_err_q <= host_err_d;
    end
  end

  assign aborted_o   = aborted_q;
  assign ovf_any_o   = ovf_any_q;
  assign host_err_o  = host_err_q;
  assign dbg_state_o = state_q;

endmodule
